div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider in the EXE stage, for DIV/DIVU.
//  Operands come from the EXE operand muxes, already steered by the forwarding selects.
//  Writes remainder to HI and quotient to LO. Its whi/wlo strobes travel down EXE/MEM and
//  MEM/WB and feed the HI/LO forwarding selects.
//  Stalls the front of the pipeline while an iteration is in flight.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count = WIDTH
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      DIV/DIVU valid in EXE this cycle
//  signed_op     in   1      1 = DIV (signed), 0 = DIVU
//  flush         in   1      exception/eret cancel; kills the operation in flight
//  rs_data       in   WIDTH  dividend (post-forwarding)
//  rt_data       in   WIDTH  divisor (post-forwarding)
//  stall_req     out  1      hold IF/ID/EXE while divide is pending
//  done          out  1      result valid this cycle
//  hi_wdata      out  WIDTH  remainder
//  lo_wdata      out  WIDTH  quotient
//  whi / wlo     out  1      HI/LO write enables, equal to done
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; every output 0; internal registers 0.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: start & !flush -> latch |rs|, |rt|, sign_q = signed_op&(rs[W-1]^rt[W-1]),
//     sign_r = signed_op&rs[W-1]; cnt = 0; go to BUSY.
//   BUSY: one restoring step per cycle:
//     {rem,quo} <<= 1; if rem >= dvs then rem -= dvs and set quo[0].
//     Go to DONE when cnt == WIDTH-1; cnt is a $clog2(WIDTH)-bit counter with no wrap past WIDTH-1.
//   DONE: done=whi=wlo=1; apply sign fix-up (two's-complement negate where the sign is set);
//     return to IDLE unconditionally. A start seen in DONE is ignored.
//  stall_req = (IDLE & start & !flush) | BUSY. It is 0 in DONE so EXE advances with the result.
//  Latency: start to done = WIDTH+1 cycles (33 for WIDTH=32).
//  Back-to-back divides: the second start arrives in the cycle after DONE, in IDLE; it is accepted.
//  Divide by zero: no trap. lo = all-ones, hi = dividend for DIVU and for DIV with positive rs.
//    Sign fix-up still applies; the values are deterministic, not X.
//  Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Magnitude arithmetic is WIDTH+1 bits.
//  flush in any state: state -> IDLE next edge; done/whi/wlo held 0 that cycle; no HI/LO write.
//    flush wins over a simultaneous start.
//  Operands are sampled only at acceptance; later changes to rs/rt_data are ignored.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//    In IDLE on acceptance, if rt==0 or |rs|<|rt| (unsigned compare of magnitudes), skip BUSY.
//    Go straight to DONE with quo=0 (rt!=0) or all-ones (rt==0), rem=|rs|.
//    Latency is then 1 cycle (start to done); stall_req is asserted only in the accepting cycle.
//  DIV_EARLY_OUT_EN undefined: every operation takes WIDTH+1 cycles, as above.
// STRUCTURE
//  Shared define header (alongside COP0 defines): DIV_ST_IDLE/BUSY/DONE 2-bit encodings, DIV_WIDTH.
//  Sub-module div_iter_step: combinational single restoring step.
//    Inputs rem, quo, dvs; outputs next rem/quo.
//  Top level holds the FSM, counter, operand/sign registers and result fix-up.
// TESTING
//  1 DIVU 100/7: start 1 cycle -> done at cycle 33; lo=14, hi=2; stall_req high cycles 0-32.
//  2 DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIV 7/-2 -> lo=-3, hi=1.
//  3 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//    DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, no X.
//  4 Flush at cycle 10 of DIVU 100/7 -> IDLE next cycle; done/whi/wlo never assert; stall_req drops.
//    New start next cycle completes correctly.
//  5 rst_n pulsed low mid-BUSY (async, between edges) -> all outputs 0 immediately.
//    IDLE after release.
//  6 Two back-to-back DIVUs (100/7 then 9/3): second accepted the cycle after first done.
//    lo=3, hi=0.
//    With DIV_EARLY_OUT_EN: DIVU 3/9 -> done 1 cycle after start, lo=0, hi=3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the EXE-stage divider: state encodings and default width.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'b00,
      DIV_ST_BUSY = 2'b01,
      DIV_ST_DONE = 2'b10
   } divState_t;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, then
// subtract the divisor from the partial remainder if it fits and record a 1.
module div_iter_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_fits;

   // The shifted remainder needs one extra bit; the difference always fits
   // back into WIDTH bits because the remainder is kept below the divisor.
   always_comb begin
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_fits  = (w_shift >= {1'b0, i_dvs});
      w_diff  = w_shift[WIDTH-1:0] - i_dvs;
      o_rem   = w_fits ? w_diff : w_shift[WIDTH-1:0];
      o_quo   = {i_quo[WIDTH-2:0], w_fits};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in EXE. Remainder goes to HI,
// quotient to LO. Optional macro DIV_EARLY_OUT_EN skips the iterations when
// the divisor is zero or the dividend magnitude is below the divisor's.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic             flush,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata,
   output logic             whi,
   output logic             wlo
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   divState_t        r_state;
   divState_t        w_nextState;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_signQ;
   logic             r_signR;

   logic             w_accept;
   logic             w_earlyOut;
   logic [WIDTH-1:0] w_rsMag;
   logic [WIDTH-1:0] w_rtMag;
   logic [WIDTH-1:0] w_stepRem;
   logic [WIDTH-1:0] w_stepQuo;

   // Operand magnitudes; only signed divides of negative values get negated.
   assign w_rsMag = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
   assign w_rtMag = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

`ifdef DIV_EARLY_OUT_EN
   assign w_earlyOut = (rt_data == '0) || (w_rsMag < w_rtMag);
`else
   assign w_earlyOut = 1'b0;
`endif

   div_iter_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_stepRem),
      .o_quo (w_stepQuo)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= DIV_ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus stall/done; flush always returns to IDLE and masks done.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      stall_req   = 1'b0;
      done        = 1'b0;
      case (r_state)
         DIV_ST_IDLE: begin
            if (start && !flush) begin
               w_accept    = 1'b1;
               stall_req   = 1'b1;
               w_nextState = w_earlyOut ? DIV_ST_DONE : DIV_ST_BUSY;
            end
         end
         DIV_ST_BUSY: begin
            stall_req = 1'b1;
            if (flush) begin
               w_nextState = DIV_ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState = DIV_ST_DONE;
            end
         end
         DIV_ST_DONE: begin
            done        = !flush;
            w_nextState = DIV_ST_IDLE;
         end
         default: begin
            w_nextState = DIV_ST_IDLE;
         end
      endcase
   end

   // Operand capture at acceptance, then one restoring step per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_signQ <= 1'b0;
         r_signR <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_dvs   <= w_rtMag;
         r_signQ <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
         r_signR <= signed_op & rs_data[WIDTH-1];
         if (w_earlyOut) begin
            r_rem <= w_rsMag;
            r_quo <= (rt_data == '0) ? '1 : '0;
         end else begin
            r_rem <= '0;
            r_quo <= w_rsMag;
         end
      end else if (r_state == DIV_ST_BUSY) begin
         r_rem <= w_stepRem;
         r_quo <= w_stepQuo;
         if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   // Sign fix-up on the result; outputs stay zero unless the result is valid.
   always_comb begin
      lo_wdata = '0;
      hi_wdata = '0;
      if (done) begin
         lo_wdata = r_signQ ? -r_quo : r_quo;
         hi_wdata = r_signR ? -r_rem : r_rem;
      end
   end

   assign whi = done;
   assign wlo = done;

endmodule
